// File: rtl/tcp_pkg.sv
// Shared TCP receive-path types: table sizing defaults and the read response layout.
package tcp_pkg;

    localparam int MAX_FLOW_CNT     = 16;
    localparam int RX_PAYLOAD_PTR_W = 16;

    // Pointers carry one extra MSB as the wrap bit.
    typedef logic [RX_PAYLOAD_PTR_W:0] rx_ptr_t;

    typedef struct packed {
        rx_ptr_t head;
        rx_ptr_t commit;
        rx_ptr_t tail;
        rx_ptr_t used;
        rx_ptr_t free;
    } rx_ptr_resp_struct;

endpackage

// File: rtl/rx_buf_ptr_table_if.sv
// Handshake bundle for the RX payload pointer table: init, advance,
// commit/tail writes and RD_PORTS read request/response channels.
interface rx_buf_ptr_table_if
    import tcp_pkg::*;
#(
    parameter int FLOWID_W = $clog2(MAX_FLOW_CNT),
    parameter int PTR_W    = RX_PAYLOAD_PTR_W,
    parameter int RD_PORTS = 2
);
    logic                init_val;
    logic [FLOWID_W-1:0] init_flowid;
    logic [PTR_W:0]      init_head;
    logic [PTR_W:0]      init_tail;
    logic                init_rdy;

    logic                adv_val;
    logic [FLOWID_W-1:0] adv_flowid;
    logic [PTR_W:0]      adv_len;
    logic                adv_rdy;
    logic                adv_err;

    logic                commit_wr_val;
    logic [FLOWID_W-1:0] commit_wr_flowid;
    logic [PTR_W:0]      commit_wr_data;
    logic                commit_wr_rdy;

    logic                tail_wr_val;
    logic [FLOWID_W-1:0] tail_wr_flowid;
    logic [PTR_W:0]      tail_wr_data;
    logic                tail_wr_rdy;

    logic [RD_PORTS-1:0]               rd_req_val;
    logic [RD_PORTS-1:0][FLOWID_W-1:0] rd_req_flowid;
    logic [RD_PORTS-1:0]               rd_req_rdy;
    logic [RD_PORTS-1:0]               rd_resp_val;
    logic [RD_PORTS-1:0]               rd_resp_rdy;
    logic [RD_PORTS-1:0][PTR_W:0]      rd_resp_head;
    logic [RD_PORTS-1:0][PTR_W:0]      rd_resp_commit;
    logic [RD_PORTS-1:0][PTR_W:0]      rd_resp_tail;
    logic [RD_PORTS-1:0][PTR_W:0]      rd_resp_used;
    logic [RD_PORTS-1:0][PTR_W:0]      rd_resp_free;

    modport slave (
        input  init_val, init_flowid, init_head, init_tail,
        output init_rdy,
        input  adv_val, adv_flowid, adv_len,
        output adv_rdy, adv_err,
        input  commit_wr_val, commit_wr_flowid, commit_wr_data,
        output commit_wr_rdy,
        input  tail_wr_val, tail_wr_flowid, tail_wr_data,
        output tail_wr_rdy,
        input  rd_req_val, rd_req_flowid, rd_resp_rdy,
        output rd_req_rdy, rd_resp_val,
        output rd_resp_head, rd_resp_commit, rd_resp_tail, rd_resp_used, rd_resp_free
    );

    modport master (
        output init_val, init_flowid, init_head, init_tail,
        input  init_rdy,
        output adv_val, adv_flowid, adv_len,
        input  adv_rdy, adv_err,
        output commit_wr_val, commit_wr_flowid, commit_wr_data,
        input  commit_wr_rdy,
        output tail_wr_val, tail_wr_flowid, tail_wr_data,
        input  tail_wr_rdy,
        output rd_req_val, rd_req_flowid, rd_resp_rdy,
        input  rd_req_rdy, rd_resp_val,
        input  rd_resp_head, rd_resp_commit, rd_resp_tail, rd_resp_used, rd_resp_free
    );

endinterface

// File: rtl/rx_ptr_table_rd_port.sv
// One read port: one-entry output register over the table's next-state
// snapshot, with optional occupancy (RX_PTR_TABLE_OCC_EN) computed from
// the same snapshot.
module rx_ptr_table_rd_port #(
    parameter int PTR_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_val,
    output logic         req_rdy,
    output logic         resp_val,
    input  logic         resp_rdy,
    input  logic [PTR_W:0] nxt_head,
    input  logic [PTR_W:0] nxt_commit,
    input  logic [PTR_W:0] nxt_tail,
    output logic [PTR_W:0] head,
    output logic [PTR_W:0] commit,
    output logic [PTR_W:0] tail,
    output logic [PTR_W:0] used,
    output logic [PTR_W:0] free
);
    typedef struct packed {
        logic [PTR_W:0] head;
        logic [PTR_W:0] commit;
        logic [PTR_W:0] tail;
        logic [PTR_W:0] used;
        logic [PTR_W:0] free;
    } resp_t;

`ifdef RX_PTR_TABLE_OCC_EN
    localparam logic [PTR_W:0] CAP = {1'b1, {PTR_W{1'b0}}};
`endif

    resp_t          snap;
    resp_t          resp_q;
    logic           val_q;
    logic [PTR_W:0] occ;
    logic           fire;

    assign req_rdy = ~val_q | resp_rdy;
    assign fire    = req_val & req_rdy;

    // Capture pointers and occupancy from the write-first snapshot.
    always_comb begin
        snap        = '0;
        occ         = '0;
        snap.head   = nxt_head;
        snap.commit = nxt_commit;
        snap.tail   = nxt_tail;
`ifdef RX_PTR_TABLE_OCC_EN
        occ         = nxt_tail - nxt_head;
        snap.used   = occ;
        snap.free   = CAP - occ;
`endif
    end

    // Output register: load on accept, drop valid once the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= 1'b0;
            resp_q <= '0;
        end else if (fire) begin
            val_q  <= 1'b1;
            resp_q <= snap;
        end else if (resp_rdy) begin
            val_q  <= 1'b0;
        end
    end

    assign resp_val = val_q;
    assign head     = resp_q.head;
    assign commit   = resp_q.commit;
    assign tail     = resp_q.tail;
    assign used     = resp_q.used;
    assign free     = resp_q.free;

endmodule

// File: rtl/rx_buf_ptr_table.sv
// Per-flow head/commit/tail pointer table for RX payload buffers.
// Init wins over all writers; advance clamps at commit; reads are write-first.
// Optional occupancy outputs: define RX_PTR_TABLE_OCC_EN.
module rx_buf_ptr_table
    import tcp_pkg::*;
#(
    parameter int FLOW_CNT = MAX_FLOW_CNT,
    parameter int FLOWID_W = $clog2(FLOW_CNT),
    parameter int PTR_W    = RX_PAYLOAD_PTR_W,
    parameter int RD_PORTS = 2
) (
    input logic clk,
    input logic rst,
    rx_buf_ptr_table_if.slave bus
);
    typedef logic [PTR_W:0] ptr_t;

    localparam logic [FLOWID_W:0] FLOW_LIM = FLOW_CNT[FLOWID_W:0];

    ptr_t head_q   [FLOW_CNT];
    ptr_t commit_q [FLOW_CNT];
    ptr_t tail_q   [FLOW_CNT];
    ptr_t head_d   [FLOW_CNT];
    ptr_t commit_d [FLOW_CNT];
    ptr_t tail_d   [FLOW_CNT];

    logic adv_fire, commit_fire, tail_fire;
    logic adv_clamp, adv_err_q;
    ptr_t adv_h, adv_c, adv_avail, adv_head_nxt;

    logic [RD_PORTS-1:0]          rd_req_rdy, rd_resp_val;
    logic [RD_PORTS-1:0][PTR_W:0] resp_head, resp_commit, resp_tail, resp_used, resp_free;

    // Init stalls every other writer so the entry it rewrites is never contended.
    assign bus.init_rdy      = 1'b1;
    assign bus.adv_rdy       = ~bus.init_val;
    assign bus.commit_wr_rdy = ~bus.init_val;
    assign bus.tail_wr_rdy   = ~bus.init_val;

    assign adv_fire    = bus.adv_val       & ~bus.init_val;
    assign commit_fire = bus.commit_wr_val & ~bus.init_val;
    assign tail_fire   = bus.tail_wr_val   & ~bus.init_val;

    // Advance against the pre-update commit; modular distance handles the wrap bit.
    always_comb begin
        adv_h        = head_q[bus.adv_flowid];
        adv_c        = commit_q[bus.adv_flowid];
        adv_avail    = adv_c - adv_h;
        adv_clamp    = bus.adv_len > adv_avail;
        adv_head_nxt = adv_clamp ? adv_c : adv_h + bus.adv_len;
    end

    // Next-state table: feeds both the flops and the write-first read ports.
    always_comb begin
        head_d   = head_q;
        commit_d = commit_q;
        tail_d   = tail_q;
        if (adv_fire)    head_d[bus.adv_flowid]         = adv_head_nxt;
        if (commit_fire) commit_d[bus.commit_wr_flowid] = bus.commit_wr_data;
        if (tail_fire)   tail_d[bus.tail_wr_flowid]     = bus.tail_wr_data;
        if (bus.init_val) begin
            head_d[bus.init_flowid]   = bus.init_head;
            commit_d[bus.init_flowid] = bus.init_tail;
            tail_d[bus.init_flowid]   = bus.init_tail;
        end
    end

    // Table storage and registered clamp indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FLOW_CNT; i++) begin
                head_q[i]   <= '0;
                commit_q[i] <= '0;
                tail_q[i]   <= '0;
            end
            adv_err_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            commit_q  <= commit_d;
            tail_q    <= tail_d;
            adv_err_q <= adv_fire & adv_clamp;
        end
    end

    assign bus.adv_err = adv_err_q;

    // Out-of-range flow ids are a caller bug; flag them in simulation.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.init_val)      assert ({1'b0, bus.init_flowid} < FLOW_LIM);
            if (bus.adv_val)       assert ({1'b0, bus.adv_flowid} < FLOW_LIM);
            if (bus.commit_wr_val) assert ({1'b0, bus.commit_wr_flowid} < FLOW_LIM);
            if (bus.tail_wr_val)   assert ({1'b0, bus.tail_wr_flowid} < FLOW_LIM);
            for (int p = 0; p < RD_PORTS; p++)
                if (bus.rd_req_val[p]) assert ({1'b0, bus.rd_req_flowid[p]} < FLOW_LIM);
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        rx_ptr_table_rd_port #(.PTR_W(PTR_W)) u_rd (
            .clk        (clk),
            .rst        (rst),
            .req_val    (bus.rd_req_val[p]),
            .req_rdy    (rd_req_rdy[p]),
            .resp_val   (rd_resp_val[p]),
            .resp_rdy   (bus.rd_resp_rdy[p]),
            .nxt_head   (head_d[bus.rd_req_flowid[p]]),
            .nxt_commit (commit_d[bus.rd_req_flowid[p]]),
            .nxt_tail   (tail_d[bus.rd_req_flowid[p]]),
            .head       (resp_head[p]),
            .commit     (resp_commit[p]),
            .tail       (resp_tail[p]),
            .used       (resp_used[p]),
            .free       (resp_free[p])
        );
    end

    assign bus.rd_req_rdy     = rd_req_rdy;
    assign bus.rd_resp_val    = rd_resp_val;
    assign bus.rd_resp_head   = resp_head;
    assign bus.rd_resp_commit = resp_commit;
    assign bus.rd_resp_tail   = resp_tail;
    assign bus.rd_resp_used   = resp_used;
    assign bus.rd_resp_free   = resp_free;

endmodule
